sram_ctrl: RTL and testbench

SRAM_CTRL -- requirements
Module: sram_ctrl

---
 rtl/sram_ctrl.sv | 111 +++++++++++
 tb/tb_sram_ctrl.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/sram_ctrl.sv
// Sequencer for a single-port SRAM macro: latches one request, drives word line,
// byte select and data for three cycles, fires one access strobe, returns masked read data.
//
// state   | meaning
// IDLE    | ready for a request; array lines quiet
// SETUP   | word line, byte select and write data settle on the array
// PULSE   | one-cycle read or write strobe
// CAPTURE | array output settles; sampled at the end of this cycle
// RESP    | one-cycle completion pulse with masked read data
module sram_ctrl #(
  parameter int ADDR_W = 6
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic                     req_we,
  input  logic [ADDR_W-1:0]        req_addr,
  input  logic [3:0]               req_be,
  input  logic [31:0]              req_wdata,
  output logic                     resp_valid,
  output logic [31:0]              resp_rdata,
  output logic [(1<<ADDR_W)-1:0]   wl,
  output logic [3:0]               byte_sel,
  output logic [31:0]              arr_datain,
  input  logic [31:0]              arr_dataout,
  output logic                     read_pulse,
  output logic                     write_pulse
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [DEPTH-1:0] WL_ONE = {{(DEPTH-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    PULSE,
    CAPTURE,
    RESP
  } state_t;

  state_t     state;
  logic       we_q;
  logic [3:0] be_q;

  function automatic logic [31:0] be_mask(input logic [3:0] be);
    return {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
  endfunction

  assign req_ready = (state == IDLE) && !rst;

  // wl and arr_datain double as the latched address and write data.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      we_q        <= 1'b0;
      be_q        <= 4'd0;
      wl          <= '0;
      byte_sel    <= 4'd0;
      arr_datain  <= 32'd0;
      read_pulse  <= 1'b0;
      write_pulse <= 1'b0;
      resp_valid  <= 1'b0;
      resp_rdata  <= 32'd0;
    end else begin
      read_pulse  <= 1'b0;
      write_pulse <= 1'b0;
      resp_valid  <= 1'b0;
      resp_rdata  <= 32'd0;
      case (state)
        IDLE: begin
          if (req_valid) begin
            we_q <= req_we;
            be_q <= req_be;
            if (req_be != 4'd0) begin
              state      <= SETUP;
              wl         <= WL_ONE << req_addr;
              byte_sel   <= req_be;
              arr_datain <= req_wdata;
            end else begin
              state      <= RESP;
              resp_valid <= 1'b1;
            end
          end
        end
        SETUP: begin
          state       <= PULSE;
          write_pulse <= we_q;
          read_pulse  <= !we_q;
        end
        PULSE: begin
          state <= CAPTURE;
        end
        CAPTURE: begin
          state      <= RESP;
          resp_valid <= 1'b1;
          resp_rdata <= we_q ? 32'd0 : (arr_dataout & be_mask(be_q));
          wl         <= '0;
          byte_sel   <= 4'd0;
        end
        RESP: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sram_ctrl.sv
// Randomized bench for sram_ctrl: a behavioural array model answers the strobes,
// a transaction-level reference predicts per-cycle outputs and a response scoreboard.
module tb_sram_ctrl;

  localparam int ADDR_W = 6;
  localparam int DEPTH  = 64;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              req_valid = 1'b0;
  logic              req_we = 1'b0;
  logic [ADDR_W-1:0] req_addr = '0;
  logic [3:0]        req_be = 4'd0;
  logic [31:0]       req_wdata = 32'd0;
  logic              req_ready;
  logic              resp_valid;
  logic [31:0]       resp_rdata;
  logic [DEPTH-1:0]  wl;
  logic [3:0]        byte_sel;
  logic [31:0]       arr_datain;
  logic [31:0]       arr_q = 32'd0;
  logic              read_pulse;
  logic              write_pulse;

  sram_ctrl #(.ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_be(req_be), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .wl(wl), .byte_sel(byte_sel), .arr_datain(arr_datain), .arr_dataout(arr_q),
    .read_pulse(read_pulse), .write_pulse(write_pulse)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  always @(posedge clk) cyc++;

  function automatic logic [31:0] init_word(input int w);
    return (32'(w) * 32'h01030507) ^ 32'h5A5AA5A5;
  endfunction

  function automatic logic [31:0] mask32(input logic [3:0] be);
    logic [31:0] m;
    for (int b = 0; b < 4; b++) m[8*b +: 8] = be[b] ? 8'hFF : 8'h00;
    return m;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, act, exp);
    end
  endtask

  // Behavioural SRAM: writes on the strobe, read data lands after the strobe edge, noise otherwise.
  logic [31:0] phys [DEPTH];
  logic [31:0] rd_word;
  always @(posedge clk) begin
    rd_word = 32'd0;
    for (int w = 0; w < DEPTH; w++) begin
      if (wl[w]) begin
        rd_word |= phys[w];
        if (write_pulse)
          for (int b = 0; b < 4; b++)
            if (byte_sel[b]) phys[w][8*b +: 8] = arr_datain[8*b +: 8];
      end
    end
    arr_q <= read_pulse ? rd_word : $urandom;
  end

  // Reference model: one transaction in flight, timing from acceptance edge a.
  typedef struct {
    int          at;
    logic [31:0] rdata;
  } resp_t;

  resp_t       rq[$];
  logic [31:0] ref_mem [DEPTH];
  int          win_lo = -1, win_hi = -2, pulse_at = -1, free_at = 0, last_acc = -1;
  logic        w_we = 1'b0;
  logic [5:0]  w_addr = '0;
  logic [3:0]  w_be = '0;
  logic [31:0] w_wdata = '0;
  logic        rst_prev = 1'b1;
  logic        in_win;
  logic [31:0] last_rdata = '0;

  always @(negedge clk) begin
    if (cyc >= 1) begin
      in_win = (cyc >= win_lo) && (cyc <= win_hi);
      chk("wl", 64'(wl), in_win ? (64'd1 << w_addr) : 64'd0);
      chk("byte_sel", 64'(byte_sel), in_win ? 64'(w_be) : 64'd0);
      if (in_win) chk("arr_datain", 64'(arr_datain), 64'(w_wdata));
      if (rst_prev) chk("arr_datain_rst", 64'(arr_datain), 64'd0);
      chk("write_pulse", 64'(write_pulse), 64'((cyc == pulse_at) && w_we));
      chk("read_pulse", 64'(read_pulse), 64'((cyc == pulse_at) && !w_we));
      chk("req_ready", 64'(req_ready), 64'(!rst && (cyc >= free_at)));
      if ((cyc == pulse_at) && w_we)
        for (int b = 0; b < 4; b++)
          if (w_be[b]) ref_mem[w_addr][8*b +: 8] = w_wdata[8*b +: 8];

      while (rq.size() > 0 && rq[0].at < cyc) begin
        checks++; errors++;
        $display("FAIL resp_missing cyc=%0d got=none want=resp_at_%0d", cyc, rq[0].at);
        void'(rq.pop_front());
      end
      if (resp_valid) begin
        if (rq.size() == 0) begin
          checks++; errors++;
          $display("FAIL resp_unexpected cyc=%0d got=resp want=none", cyc);
        end else begin
          chk("resp_cycle", 64'(cyc), 64'(rq[0].at));
          chk("resp_rdata", 64'(resp_rdata), 64'(rq[0].rdata));
          last_rdata = resp_rdata;
          void'(rq.pop_front());
        end
      end else begin
        chk("resp_rdata_idle", 64'(resp_rdata), 64'd0);
      end

      if (rst) begin
        rq.delete();
        win_lo = -1; win_hi = -2; pulse_at = -1;
        free_at = cyc + 1;
      end else if (req_valid && cyc >= free_at) begin
        last_acc = cyc + 1;
        if (req_be != 4'd0) begin
          win_lo = last_acc; win_hi = last_acc + 2; pulse_at = last_acc + 1;
          w_we = req_we; w_addr = req_addr; w_be = req_be; w_wdata = req_wdata;
          rq.push_back('{at: last_acc + 3,
                         rdata: req_we ? 32'd0 : (ref_mem[req_addr] & mask32(req_be))});
          free_at = last_acc + 4;
        end else begin
          rq.push_back('{at: last_acc, rdata: 32'd0});
          free_at = last_acc + 1;
        end
      end
      rst_prev = rst;
    end
  end

  task automatic drive(input logic we, input logic [5:0] addr, input logic [3:0] be,
                       input logic [31:0] wd, output int acc_edge);
    req_valid = 1'b1; req_we = we; req_addr = addr; req_be = be; req_wdata = wd;
    acc_edge = -1;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (last_acc == cyc) begin
        acc_edge = cyc;
        break;
      end
    end
    checks++;
    if (acc_edge < 0) begin
      errors++;
      $display("FAIL accept_timeout cyc=%0d got=no_accept want=accept", cyc);
    end
  endtask

  task automatic idle(input int n);
    req_valid = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  int a1, a2;

  initial begin
    for (int w = 0; w < DEPTH; w++) begin
      phys[w]    = init_word(w);
      ref_mem[w] = init_word(w);
    end
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    idle(1);

    drive(1'b1, 6'd5, 4'hF, 32'hDEADBEEF, a1); idle(6);
    drive(1'b0, 6'd5, 4'hF, 32'h0, a1);        idle(6);
    chk("rd_deadbeef", 64'(last_rdata), 64'h0000_0000_DEAD_BEEF);

    drive(1'b1, 6'd9, 4'hF, 32'h11223344, a1); idle(6);
    drive(1'b0, 6'd9, 4'b0101, 32'h0, a1);     idle(6);
    chk("rd_partial", 64'(last_rdata), 64'h0000_0000_0022_0044);

    drive(1'b1, 6'd12, 4'h0, 32'hFFFFFFFF, a1); idle(3);
    drive(1'b0, 6'd12, 4'hF, 32'h0, a1);        idle(6);
    chk("rd_after_be0", 64'(last_rdata), 64'(init_word(12)));

    drive(1'b0, 6'd3, 4'hF, 32'h0, a1);
    drive(1'b0, 6'd40, 4'hF, 32'h0, a2); idle(6);
    chk("b2b_gap", 64'(a2 - a1), 64'd5);
    drive(1'b0, 6'd1, 4'h0, 32'h0, a1);
    drive(1'b1, 6'd2, 4'h0, 32'h0, a2); idle(3);
    chk("b2b_gap_be0", 64'(a2 - a1), 64'd2);

    drive(1'b1, 6'd20, 4'hF, 32'hCAFEF00D, a1);
    @(posedge clk); #1;
    rst = 1'b1; req_valid = 1'b1; req_we = 1'b0; req_addr = 6'd30; req_be = 4'hF;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0; req_valid = 1'b0;
    @(negedge clk);
    chk("ready_after_rst", 64'(req_ready), 64'd1);
    idle(8);

    drive(1'b0, 6'd63, 4'hF, 32'h0, a1); idle(6);
    chk("rd_top", 64'(last_rdata), 64'(init_word(63)));

    repeat (600) begin
      req_valid = 1'($urandom_range(0, 1));
      req_we    = 1'($urandom_range(0, 1));
      req_addr  = 6'($urandom);
      req_be    = ($urandom_range(0, 3) == 0) ? 4'd0 : 4'($urandom);
      req_wdata = $urandom;
      @(posedge clk); #1;
    end
    idle(10);
    chk("queue_empty", 64'(rq.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
